// File: rtl/fpga_ccff_loader.sv
// Bitstream loader feeding NUM_CHAINS parallel configuration chains from a valid/ready stream.
// Optional chain integrity check via marker word: define CCFF_TAIL_CHECK_EN.

// state | meaning
// IDLE  | waiting for start, fabric not in config mode
// PRE   | marker word push (tail check build) or one-cycle setup
// LOAD  | accepting CHAIN_LEN data words, one shift per accept
// FIN   | last shift in flight, no new shift issued
// DONE  | load complete, waiting for start to reload
module fpga_ccff_loader #(
  parameter int NUM_CHAINS = 12,
  parameter int CHAIN_LEN  = 1024,
  parameter int CNT_W      = 11
) (
  input  logic                  prog_clk,
  input  logic                  pReset,
  input  logic                  start,
  input  logic                  cfg_valid,
  input  logic [NUM_CHAINS-1:0] cfg_data,
  output logic                  cfg_ready,
  output logic [NUM_CHAINS-1:0] ccff_head,
  input  logic [NUM_CHAINS-1:0] ccff_tail,
  output logic                  shift_en,
  output logic                  config_enable,
  output logic                  busy,
  output logic                  done,
  output logic [NUM_CHAINS-1:0] error
);

`ifdef CCFF_TAIL_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif

  // counter tracks total shifts issued; the marker counts as shift 1
  localparam logic [CNT_W-1:0] LAST_M1 = CNT_W'(CHAIN_LEN - 1 + int'(CHECK));
  localparam logic [CNT_W-1:0] TAIL_AT = CNT_W'(CHAIN_LEN);

  typedef enum logic [2:0] {IDLE, PRE, LOAD, FIN, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic             chk_pend;

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state         <= IDLE;
      counter       <= '0;
      chk_pend      <= 1'b0;
      ccff_head     <= '0;
      shift_en      <= 1'b0;
      cfg_ready     <= 1'b0;
      config_enable <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= '0;
    end else begin
      shift_en <= 1'b0;
      // marker sits in the last flip-flop the cycle after the CHAIN_LEN-th shift
      chk_pend <= CHECK && shift_en && (counter == TAIL_AT);
      if (chk_pend) error <= error | ~ccff_tail;

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state         <= PRE;
            done          <= 1'b0;
            error         <= '0;
            chk_pend      <= 1'b0;
            busy          <= 1'b1;
            config_enable <= 1'b1;
            counter       <= '0;
          end
        end
        PRE: begin
          if (CHECK) begin
            ccff_head <= '1;
            shift_en  <= 1'b1;
            counter   <= CNT_W'(1);
          end else begin
            counter   <= '0;
          end
          cfg_ready <= 1'b1;
          state     <= LOAD;
        end
        LOAD: begin
          if (cfg_valid && cfg_ready) begin
            ccff_head <= cfg_data;
            shift_en  <= 1'b1;
            if (counter != '1) counter <= counter + 1'b1;
            if (counter == LAST_M1) begin
              cfg_ready <= 1'b0;
              state     <= FIN;
            end
          end
        end
        FIN: begin
          state         <= DONE;
          done          <= 1'b1;
          busy          <= 1'b0;
          config_enable <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpga_ccff_loader.sv
// Directed bench for fpga_ccff_loader with CHAIN_LEN=4 and a shift-register chain model.
// Expectations follow CCFF_TAIL_CHECK_EN when the bench is built with it.
module tb_fpga_ccff_loader;
  localparam int NC = 12;
  localparam int CL = 4;
`ifdef CCFF_TAIL_CHECK_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  logic          prog_clk = 1'b0;
  logic          pReset = 1'b1;
  logic          start = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [NC-1:0] cfg_data = '0;
  logic          cfg_ready;
  logic [NC-1:0] ccff_head;
  logic [NC-1:0] ccff_tail;
  logic          shift_en;
  logic          config_enable;
  logic          busy;
  logic          done;
  logic [NC-1:0] error;

  fpga_ccff_loader #(.NUM_CHAINS(NC), .CHAIN_LEN(CL), .CNT_W(11)) dut (
    .prog_clk(prog_clk), .pReset(pReset), .start(start), .cfg_valid(cfg_valid),
    .cfg_data(cfg_data), .cfg_ready(cfg_ready), .ccff_head(ccff_head),
    .ccff_tail(ccff_tail), .shift_en(shift_en), .config_enable(config_enable),
    .busy(busy), .done(done), .error(error)
  );

  always #5 prog_clk = ~prog_clk;

  // fabric chain model: chain[0] is the head end, chain[CL-1] drives the tail
  logic [NC-1:0] chain [CL];
  logic [NC-1:0] stuck_mask = '0;
  int            shift_total;

  always @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      for (int i = 0; i < CL; i++) chain[i] <= '0;
      shift_total <= 0;
    end else if (shift_en) begin
      chain[0] <= ccff_head;
      for (int i = 1; i < CL; i++) chain[i] <= chain[i-1];
      shift_total <= shift_total + 1;
    end
  end

  assign ccff_tail = chain[CL-1] & ~stuck_mask;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_shift_en"}, 32'(shift_en), 0);
    chk({tag, "_cfg_ready"}, 32'(cfg_ready), 0);
    chk({tag, "_config_enable"}, 32'(config_enable), 0);
    chk({tag, "_ccff_head"}, 32'(ccff_head), 0);
    chk({tag, "_error"}, 32'(error), 0);
  endtask

  // One full load; gap_mode 1 offers a word every third cycle, busy_start pulses start mid-load
  task automatic run_load(input string tag, input logic [4*NC-1:0] wp, input int gap_mode,
                          input bit busy_start, input logic [NC-1:0] exp_err);
    logic [NC-1:0] words [CL];
    int n_acc, base, last_acc_cyc, done_cyc;
    bit acc, acc_prev;
    for (int k = 0; k < CL; k++) words[k] = wp[k*NC +: NC];
    base = shift_total;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_pre_busy"}, 32'(busy), 1);
    chk({tag, "_pre_cfgen"}, 32'(config_enable), 1);
    chk({tag, "_pre_done_clr"}, 32'(done), 0);
    chk({tag, "_pre_err_clr"}, 32'(error), 0);
    chk({tag, "_pre_ready"}, 32'(cfg_ready), 0);
    tick();
    chk({tag, "_marker_shift"}, 32'(shift_en), 32'(CHK));
    if (CHK == 1) chk({tag, "_marker_head"}, 32'(ccff_head), 32'({NC{1'b1}}));
    chk({tag, "_load_ready"}, 32'(cfg_ready), 1);
    n_acc = 0; acc_prev = 1'b0; last_acc_cyc = -100; done_cyc = -1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc > 0) begin
        chk({tag, "_shift_follows_accept"}, 32'(shift_en), 32'(acc_prev));
        if (acc_prev) chk({tag, "_head_word"}, 32'(ccff_head), 32'(words[n_acc-1]));
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      start = busy_start && (cyc == 1);
      cfg_valid = (gap_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      cfg_data = (n_acc < CL) ? words[n_acc] : 12'hABC;
      acc = cfg_valid && cfg_ready;
      if (acc) begin
        n_acc++;
        last_acc_cyc = cyc;
      end
      acc_prev = acc;
      tick();
      start = 1'b0;
    end
    chk({tag, "_done_seen"}, 32'(done_cyc >= 0), 1);
    chk({tag, "_done_latency"}, 32'(done_cyc - last_acc_cyc), 2);
    chk({tag, "_words_accepted"}, 32'(n_acc), CL);
    chk({tag, "_shift_count"}, 32'(shift_total - base), 32'(CL + CHK));
    chk({tag, "_ready_after"}, 32'(cfg_ready), 0);
    chk({tag, "_busy_after"}, 32'(busy), 0);
    chk({tag, "_cfgen_after"}, 32'(config_enable), 0);
    for (int k = 0; k < CL; k++) chk({tag, "_chain"}, 32'(chain[CL-1-k]), 32'(words[k]));
    chk({tag, "_error"}, 32'(error), 32'((CHK == 1) ? exp_err : '0));
    // stream still offered in DONE must not be consumed
    cfg_valid = 1'b1;
    base = shift_total;
    tick(); tick();
    chk({tag, "_done_no_shift"}, 32'(shift_total - base), 0);
    chk({tag, "_done_ready"}, 32'(cfg_ready), 0);
    chk({tag, "_done_sticky"}, 32'(done), 1);
    cfg_valid = 1'b0;
  endtask

  initial begin
    int base;
    #1;
    check_all_zero("reset");
    tick(); tick();
    @(negedge prog_clk);
    pReset = 1'b0;
    tick();
    check_all_zero("idle");

    cfg_valid = 1'b1;
    cfg_data = 12'h5A5;
    base = shift_total;
    tick(); tick(); tick();
    chk("idle_valid_no_shift", 32'(shift_total - base), 0);
    chk("idle_valid_not_ready", 32'(cfg_ready), 0);
    cfg_valid = 1'b0;

    run_load("basic", {12'h008, 12'h004, 12'h002, 12'h001}, 0, 1'b0, '0);
    run_load("gaps", {12'h800, 12'h3C3, 12'hF0F, 12'h123}, 1, 1'b1, '0);

    // reset in the middle of a load with two words accepted
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    cfg_valid = 1'b1;
    cfg_data = 12'h111;
    tick();
    cfg_data = 12'h222;
    tick();
    cfg_valid = 1'b0;
    chk("midload_busy", 32'(busy), 1);
    pReset = 1'b1;
    #1;
    check_all_zero("midload_reset");
    tick();
    @(negedge prog_clk);
    pReset = 1'b0;
    tick();
    check_all_zero("post_reset_idle");
    run_load("after_reset", {12'hAAA, 12'h555, 12'h0F0, 12'hE01}, 0, 1'b0, '0);

    stuck_mask = 12'h020;
    run_load("stuck5", {12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF}, 0, 1'b0, 12'h020);
    stuck_mask = '0;
    run_load("reload", {12'h008, 12'h004, 12'h002, 12'h001}, 1, 1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
